// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point datapath blocks:
//   - default format widths (binary32) and the exponent bias helper
//   - operand classification enum
//   - exception flag record, bit order {invalid, overflow, underflow, inexact}
//   - canonical quiet-NaN encoding helper
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic [1:0] {
        FP_ZERO = 2'd0,
        FP_NORM = 2'd1,
        FP_INF  = 2'd2,
        FP_NAN  = 2'd3
    } fp_class_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Exponent bias 2^(exp_w-1)-1.
    function automatic int fp_bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 1)) - 32'sd1;
    endfunction

    // Canonical qNaN {0, all-ones exponent, 1, 0...}; caller truncates to its width.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe_if
// Streaming operand/result bundle for the pipelined FP multiplier.
//   in_valid/in_ready : operand pair handshake, a/b packed operands
//   out_valid/out_ready: result handshake, result packed product, flags
// master = producer/consumer side (testbench or surrounding datapath),
// slave  = the multiplier.
// -----------------------------------------------------------------------------
interface fp_mul_pipe_if #(
    parameter int W = 32
);
    import fp_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    result;
    fp_flags_t       flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fp_round_rne.sv
// -----------------------------------------------------------------------------
// fp_round_rne
// Combinational normalise + round-to-nearest-even + pack for a product of two
// hidden-1 significands. Flushes results below the normal range to signed zero
// and saturates results above it to signed infinity.
// Ports:
//   i_sign   : result sign
//   i_exp    : biased exponent before normalisation (signed, EXP_W+2 bits)
//   i_prod   : 2*MAN_W+2 bit significand product, value in [1,4)
//   o_result : packed {sign, exp, frac}
//   o_flags  : {invalid(0), overflow, underflow, inexact}
// -----------------------------------------------------------------------------
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                    i_sign,
    input  logic signed [EXP_W+1:0] i_exp,
    input  logic [2*MAN_W+1:0]      i_prod,
    output logic [EXP_W+MAN_W:0]    o_result,
    output fp_flags_t               o_flags
);

    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;

    logic                   w_msb;
    logic [2*MAN_W+1:0]     w_norm;
    logic signed [EW-1:0]   w_exp_n;
    logic signed [EW-1:0]   w_exp_f;
    logic                   w_g;
    logic                   w_r;
    logic                   w_s;
    logic                   w_inc;
    logic [MAN_W+1:0]       w_rnd;
    logic [MAN_W-1:0]       w_frac;

    // A set MSB means the product is in [2,4): take it as is and bump the
    // exponent; otherwise shift left so the hidden 1 always sits at the top.
    assign w_msb   = i_prod[2*MAN_W+1];
    assign w_norm  = w_msb ? i_prod : {i_prod[2*MAN_W:0], 1'b0};
    assign w_exp_n = i_exp + {{(EW-1){1'b0}}, w_msb};

    assign w_g   = w_norm[MAN_W];
    assign w_r   = w_norm[MAN_W-1];
    assign w_s   = |w_norm[MAN_W-2:0];
    assign w_inc = w_g & (w_r | w_s | w_norm[MAN_W+1]);

    // Round the {hidden, fraction} field; a carry out means the significand
    // became 10.000..., which renormalises to a zero fraction and exp+1.
    assign w_rnd   = {1'b0, w_norm[2*MAN_W+1:MAN_W+1]} + {{(MAN_W+1){1'b0}}, w_inc};
    assign w_frac  = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_exp_f = w_exp_n + {{(EW-1){1'b0}}, w_rnd[MAN_W+1]};

    // Range check of the final exponent and packing.
    always_comb begin
        o_result = '0;
        o_flags  = '0;
        if (w_exp_f >= EXP_MAX) begin
            o_result          = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            o_flags.overflow  = 1'b1;
            o_flags.inexact   = 1'b1;
        end else if (w_exp_f <= EXP_ZERO) begin
            o_result          = {i_sign, {(EXP_W+MAN_W){1'b0}}};
            o_flags.underflow = 1'b1;
            o_flags.inexact   = 1'b1;
        end else begin
            o_result          = {i_sign, w_exp_f[EXP_W-1:0], w_frac};
            o_flags.inexact   = w_g | w_r | w_s;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// fp_mul_pipe
// Three-stage pipelined floating-point multiplier with valid/ready flow
// control, RNE rounding, flush-to-zero and exception flags.
//   stage 1: unpack, classify, sign, exponent sum, special-value result
//   stage 2: significand multiply
//   stage 3: normalise/round/pack (fp_round_rne) into the output register
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_mul_pipe_if slave (operands in, result/flags out)
// The whole pipeline advances together when the output is empty or being
// taken; otherwise every stage holds, bubbles included.
// -----------------------------------------------------------------------------
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mul_pipe_if.slave  bus
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS_E = EW'(fp_bias(EXP_W));
    localparam logic [W-1:0]         QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        fp_class_t c;
        if (e == {EXP_W{1'b0}}) begin
            c = FP_ZERO;
        end else if (e == {EXP_W{1'b1}}) begin
            c = (f == {MAN_W{1'b0}}) ? FP_INF : FP_NAN;
        end else begin
            c = FP_NORM;
        end
        return c;
    endfunction

    logic                 w_advance;
    logic [EXP_W-1:0]     w_ea;
    logic [EXP_W-1:0]     w_eb;
    logic [MAN_W-1:0]     w_fa;
    logic [MAN_W-1:0]     w_fb;
    fp_class_t            w_ca;
    fp_class_t            w_cb;
    logic                 w_sign;
    logic signed [EW-1:0] w_exp_sum;
    logic                 w_spec;
    logic [W-1:0]         w_spec_res;
    fp_flags_t            w_spec_flags;
    logic [PW-1:0]        w_prod;
    logic [W-1:0]         w_rnd_res;
    fp_flags_t            w_rnd_flags;

    logic                 r_v1;
    logic                 r_sign1;
    logic signed [EW-1:0] r_exp1;
    logic [MAN_W:0]       r_ma1;
    logic [MAN_W:0]       r_mb1;
    logic                 r_spec1;
    logic [W-1:0]         r_spec_res1;
    fp_flags_t            r_spec_flags1;

    logic                 r_v2;
    logic                 r_sign2;
    logic signed [EW-1:0] r_exp2;
    logic [PW-1:0]        r_prod2;
    logic                 r_spec2;
    logic [W-1:0]         r_spec_res2;
    fp_flags_t            r_spec_flags2;

    logic                 r_v3;
    logic [W-1:0]         r_res3;
    fp_flags_t            r_flags3;

    // Global stall: in_ready depends only on state and out_ready.
    assign w_advance    = !r_v3 | bus.out_ready;
    assign bus.in_ready = w_advance;

    assign w_ea      = bus.a[W-2:MAN_W];
    assign w_eb      = bus.b[W-2:MAN_W];
    assign w_fa      = bus.a[MAN_W-1:0];
    assign w_fb      = bus.b[MAN_W-1:0];
    assign w_ca      = classify(w_ea, w_fa);
    assign w_cb      = classify(w_eb, w_fb);
    assign w_sign    = bus.a[W-1] ^ bus.b[W-1];
    assign w_exp_sum = EW'(w_ea) + EW'(w_eb) - BIAS_E;

    // Special-value result, highest priority first; NaN inputs raise no flag.
    always_comb begin
        w_spec       = 1'b1;
        w_spec_res   = '0;
        w_spec_flags = '0;
        if (w_ca == FP_NAN || w_cb == FP_NAN) begin
            w_spec_res = QNAN;
        end else if ((w_ca == FP_INF && w_cb == FP_ZERO) ||
                     (w_ca == FP_ZERO && w_cb == FP_INF)) begin
            w_spec_res           = QNAN;
            w_spec_flags.invalid = 1'b1;
        end else if (w_ca == FP_INF || w_cb == FP_INF) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_ca == FP_ZERO || w_cb == FP_ZERO) begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    // Stage 1 register: classified operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1          <= 1'b0;
            r_sign1       <= 1'b0;
            r_exp1        <= '0;
            r_ma1         <= '0;
            r_mb1         <= '0;
            r_spec1       <= 1'b0;
            r_spec_res1   <= '0;
            r_spec_flags1 <= '0;
        end else if (w_advance) begin
            r_v1          <= bus.in_valid;
            r_sign1       <= w_sign;
            r_exp1        <= w_exp_sum;
            r_ma1         <= {1'b1, w_fa};
            r_mb1         <= {1'b1, w_fb};
            r_spec1       <= w_spec;
            r_spec_res1   <= w_spec_res;
            r_spec_flags1 <= w_spec_flags;
        end
    end

    assign w_prod = PW'(r_ma1) * PW'(r_mb1);

    // Stage 2 register: significand product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2          <= 1'b0;
            r_sign2       <= 1'b0;
            r_exp2        <= '0;
            r_prod2       <= '0;
            r_spec2       <= 1'b0;
            r_spec_res2   <= '0;
            r_spec_flags2 <= '0;
        end else if (w_advance) begin
            r_v2          <= r_v1;
            r_sign2       <= r_sign1;
            r_exp2        <= r_exp1;
            r_prod2       <= w_prod;
            r_spec2       <= r_spec1;
            r_spec_res2   <= r_spec_res1;
            r_spec_flags2 <= r_spec_flags1;
        end
    end

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .i_sign   (r_sign2),
        .i_exp    (r_exp2),
        .i_prod   (r_prod2),
        .o_result (w_rnd_res),
        .o_flags  (w_rnd_flags)
    );

    // Stage 3 output register; empty slots present zero result and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3     <= 1'b0;
            r_res3   <= '0;
            r_flags3 <= '0;
        end else if (w_advance) begin
            r_v3     <= r_v2;
            r_res3   <= !r_v2 ? '0 : (r_spec2 ? r_spec_res2 : w_rnd_res);
            r_flags3 <= !r_v2 ? '0 : (r_spec2 ? r_spec_flags2 : w_rnd_flags);
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.result    = r_res3;
    assign bus.flags     = r_flags3;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_pipe
// Directed bench for fp_mul_pipe: binary32 and binary16 instances, latency,
// rounding, exceptions, backpressure against an integer reference model, and
// asynchronous reset with operations in flight.
// -----------------------------------------------------------------------------
module tb_fp_mul_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    fp_mul_pipe_if #(.W(32)) if32();
    fp_mul_pipe_if #(.W(16)) if16();

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act,
                               input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp_v);
        end
    endtask

    // Reference for normal operands whose product stays in range: exact
    // integer product, then round half to even on the discarded remainder.
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint unsigned ma, mb, p, q, rem, half;
        int e, ex, ey, sh;
        ma = {40'd0, 1'b1, x[22:0]};
        mb = {40'd0, 1'b1, y[22:0]};
        p  = ma * mb;
        ex = {24'd0, x[30:23]};
        ey = {24'd0, y[30:23]};
        e  = ex + ey - 127;
        if (p >= 64'h0000_8000_0000_0000) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == 64'h0000_0000_0100_0000) begin
            q = q >> 1;
            e = e + 1;
        end
        return {3'b000, (rem != 64'd0), x[31] ^ y[31], e[7:0], q[22:0]};
    endfunction

    // One operation on an idle pipe; h selects the binary16 instance.
    task automatic run_vec(input bit h, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] exp_r, input logic [3:0] exp_f,
                           input string tag);
        @(negedge clk);
        if (h) begin
            if16.in_valid = 1'b1; if16.a = va[15:0]; if16.b = vb[15:0];
        end else begin
            if32.in_valid = 1'b1; if32.a = va; if32.b = vb;
        end
        #1;
        check_value({tag, "_in_ready"}, h ? if16.in_ready : if32.in_ready, 32'd1);
        @(posedge clk); #1;
        if16.in_valid = 1'b0;
        if32.in_valid = 1'b0;
        check_value({tag, "_lat0"}, h ? if16.out_valid : if32.out_valid, 32'd0);
        @(posedge clk); #1;
        check_value({tag, "_lat1"}, h ? if16.out_valid : if32.out_valid, 32'd0);
        @(posedge clk); #1;
        check_value({tag, "_valid"}, h ? if16.out_valid : if32.out_valid, 32'd1);
        check_value({tag, "_result"}, h ? {16'd0, if16.result} : if32.result, exp_r);
        check_value({tag, "_flags"}, {28'd0, (h ? if16.flags : if32.flags)}, {28'd0, exp_f});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] pa [8];
        logic [31:0] pb [8];
        logic [35:0] exp_q [$];
        logic [35:0] ev;
        int          sent, got;
        logic        prev_stall, acc_in;
        logic [31:0] prev_res;
        logic [3:0]  prev_flags;

        rst_n = 1'b0;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_valid", if32.out_valid, 32'd0);
        check_value("rst_result", if32.result, 32'd0);
        check_value("rst_flags", {28'd0, if32.flags}, 32'd0);
        check_value("rst_in_ready", if32.in_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // binary32 directed vectors
        run_vec(1'b0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000, "mul_2x3");
        run_vec(1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, "mul_1p5sq");
        run_vec(1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, "rnd_small");
        run_vec(1'b0, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, "rnd_max");
        run_vec(1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, "ovf");
        run_vec(1'b0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, "inf_x_0");
        run_vec(1'b0, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, "unf");
        run_vec(1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, "ninf_x_2");
        run_vec(1'b0, 32'h7FA00000, 32'h00000000, 32'h7FC00000, 4'b0000, "nan_x_0");
        run_vec(1'b0, 32'hC0000000, 32'h00000000, 32'h80000000, 4'b0000, "neg_x_0");
        // binary16 directed vectors
        run_vec(1'b1, 32'h00004000, 32'h00004200, 32'h00004600, 4'b0000, "h_2x3");
        run_vec(1'b1, 32'h00007800, 32'h00007800, 32'h00007C00, 4'b0101, "h_ovf");
        run_vec(1'b1, 32'h00007C00, 32'h00000000, 32'h00007E00, 4'b1000, "h_inf_x_0");

        // Backpressure stream against the reference model.
        for (int i = 0; i < 8; i++) begin
            pa[i] = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
            pb[i] = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 23'($urandom)};
        end
        sent = 0; got = 0; prev_stall = 1'b0; prev_res = '0; prev_flags = '0;
        for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
            @(negedge clk);
            if32.out_ready = ($urandom_range(2, 0) != 0);
            if32.in_valid  = (sent < 8);
            if (sent < 8) begin
                if32.a = pa[sent];
                if32.b = pb[sent];
            end
            #1;
            check_value("bp_in_ready", if32.in_ready, {31'd0, !(if32.out_valid && !if32.out_ready)});
            if (prev_stall) begin
                check_value("bp_hold_result", if32.result, prev_res);
                check_value("bp_hold_flags", {28'd0, if32.flags}, {28'd0, prev_flags});
                check_value("bp_hold_valid", if32.out_valid, 32'd1);
            end
            acc_in = if32.in_valid && if32.in_ready;
            if (if32.out_valid && if32.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("bp_extra", if32.out_valid, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check_value("bp_result", if32.result, ev[31:0]);
                    check_value("bp_flags", {28'd0, if32.flags}, {28'd0, ev[35:32]});
                    got++;
                end
            end
            prev_stall = if32.out_valid && !if32.out_ready;
            prev_res   = if32.result;
            prev_flags = if32.flags;
            @(posedge clk);
            if (acc_in) begin
                exp_q.push_back(ref_mul(pa[sent], pb[sent]));
                sent++;
            end
        end
        check_value("bp_count", got, 32'd8);
        @(negedge clk);
        if32.in_valid  = 1'b0;
        if32.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_value("bp_no_dup", if32.out_valid, 32'd0);

        // Asynchronous reset with three operations in flight.
        @(negedge clk);
        if32.in_valid = 1'b1; if32.a = 32'h40000000; if32.b = 32'h40400000;
        repeat (3) @(posedge clk);
        #1;
        if32.in_valid = 1'b0;
        check_value("rst_pre_valid", if32.out_valid, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_value("rst_async_valid", if32.out_valid, 32'd0);
        check_value("rst_async_result", if32.result, 32'd0);
        check_value("rst_async_flags", {28'd0, if32.flags}, 32'd0);
        check_value("rst_async_in_ready", if32.in_ready, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_hold_valid", if32.out_valid, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
